dsp_mac_sequencer: RTL and testbench

//  Drives one DSP48A1 slice as a streaming multiply-accumulate engine. Accepts (a,b) pairs

---
 rtl/dsp_seq_pkg.sv | 20 ++
 rtl/dsp_tag_pipe.sv | 29 ++
 rtl/dsp_mac_sequencer.sv | 128 ++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the DSP48A1 multiply-accumulate sequencer:
// slice OPMODE encodings, datapath widths and the per-term pipeline tag.
package dsp_seq_pkg;

    localparam int A_W   = 18;
    localparam int P_W   = 48;
    localparam int OPM_W = 8;

    // Z=0, X=M : start a new sum from the product
    localparam logic [OPM_W-1:0] OPM_MUL = 8'h01;
    // Z=P, X=M : add the product to the running sum
    localparam logic [OPM_W-1:0] OPM_MAC = 8'h09;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/dsp_tag_pipe.sv
// Tag shift register that follows each term through the slice pipeline.
// Ports: clk, rst (async, active-high), en (shift enable), din (tag of the
// term presented this cycle), stage[0..LAT] (stage 0 is din itself).
module dsp_tag_pipe
    import dsp_seq_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  tag_t             din,
    output tag_t [LAT:0]     stage
);

    tag_t [LAT:1] regs;

    // Stage k describes the term whose operands entered the slice k cycles ago.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (en) begin
            regs <= {regs[LAT-1:1], din};
        end
    end

    assign stage = {regs, din};

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams (a,b) pairs into one DSP48A1 slice and returns one accumulated sum
// per N_TERMS products.
// Ports: clk, rst (async, active-high); s_valid/s_ready/s_a/s_b input pairs;
// m_valid/m_ready/m_result/m_carry result buffer; dsp_* slice operands,
// OPMODE, clock enables and reset; dsp_p/dsp_carryout slice outputs.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int LAT     = 3,
    parameter int TAG_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [A_W-1:0]   s_a,
    input  logic [A_W-1:0]   s_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [P_W-1:0]   m_result,
    output logic             m_carry,
    output logic [A_W-1:0]   dsp_a,
    output logic [A_W-1:0]   dsp_b,
    output logic [A_W-1:0]   dsp_d,
    output logic [P_W-1:0]   dsp_c,
    output logic [OPM_W-1:0] dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_cep,
    output logic             dsp_ceopmode,
    output logic             dsp_cecarryin,
    output logic             dsp_rst,
    input  logic [P_W-1:0]   dsp_p,
    input  logic             dsp_carryout
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    if (N_TERMS < 1 || LAT < 2 || TAG_W < 1) begin : g_bad_cfg
        $error("dsp_mac_sequencer: invalid N_TERMS/LAT/TAG_W");
    end

    logic             adv;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    tag_t             tag_in;
    tag_t [LAT:0]     tags;

    // A full, unread result buffer freezes the whole slice.
    assign adv     = !m_valid || m_ready;
    assign acc     = s_valid && adv;
    assign s_ready = adv;

    always_comb begin
        tag_in       = '0;
        tag_in.vld   = acc;
        tag_in.first = acc && (cnt == '0);
        tag_in.last  = acc && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (acc) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    dsp_tag_pipe #(
        .LAT (LAT)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .din   (tag_in),
        .stage (tags)
    );

    assign dsp_a = acc ? s_a : '0;
    assign dsp_b = acc ? s_b : '0;
    assign dsp_d = '0;
    assign dsp_c = '0;

    // OPMODE is registered in the slice, so it is issued one stage ahead of
    // the P update it controls.  Bubbles use MAC so P is never zeroed.
    always_comb begin
        dsp_opmode = OPM_MAC;
        unique case (1'b1)
            tags[LAT-2].vld && tags[LAT-2].first: dsp_opmode = OPM_MUL;
            default:                              dsp_opmode = OPM_MAC;
        endcase
    end

    assign dsp_cea       = adv;
    assign dsp_ceb       = adv;
    assign dsp_cem       = adv;
    assign dsp_ceopmode  = adv;
    assign dsp_cecarryin = adv;
    assign dsp_cep       = adv && tags[LAT-1].vld;

    // Raised with rst, dropped on the first edge after release so the
    // synchronously reset slice always sees one reset edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_rst <= 1'b1;
        end else begin
            dsp_rst <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_result <= '0;
            m_carry  <= 1'b0;
        end else if (adv && tags[LAT].vld && tags[LAT].last) begin
            m_valid  <= 1'b1;
            m_result <= dsp_p;
            m_carry  <= dsp_carryout;
        end else if (m_ready) begin
            m_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two instances (N_TERMS=4 and N_TERMS=1), each
// driving a behavioural DSP48A1 slice model (A1REG, MREG, PREG, OPMODEREG).
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;
    import dsp_seq_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        s_valid, s_ready, m_valid, m_ready, m_carry;
    logic [1:0][17:0]  s_a, s_b, dsp_a, dsp_b, dsp_d;
    logic [1:0][47:0]  m_result, dsp_c, dsp_p;
    logic [1:0][7:0]   dsp_opmode;
    logic [1:0]        dsp_cea, dsp_ceb, dsp_cem, dsp_cep;
    logic [1:0]        dsp_ceopmode, dsp_cecarryin, dsp_rst, dsp_carryout;

    logic [7:0] opm_log [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dsp_mac_sequencer #(
            .N_TERMS ((g == 0) ? 4 : 1),
            .LAT     (LAT),
            .TAG_W   (1)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .s_valid       (s_valid[g]),
            .s_ready       (s_ready[g]),
            .s_a           (s_a[g]),
            .s_b           (s_b[g]),
            .m_valid       (m_valid[g]),
            .m_ready       (m_ready[g]),
            .m_result      (m_result[g]),
            .m_carry       (m_carry[g]),
            .dsp_a         (dsp_a[g]),
            .dsp_b         (dsp_b[g]),
            .dsp_d         (dsp_d[g]),
            .dsp_c         (dsp_c[g]),
            .dsp_opmode    (dsp_opmode[g]),
            .dsp_cea       (dsp_cea[g]),
            .dsp_ceb       (dsp_ceb[g]),
            .dsp_cem       (dsp_cem[g]),
            .dsp_cep       (dsp_cep[g]),
            .dsp_ceopmode  (dsp_ceopmode[g]),
            .dsp_cecarryin (dsp_cecarryin[g]),
            .dsp_rst       (dsp_rst[g]),
            .dsp_p         (dsp_p[g]),
            .dsp_carryout  (dsp_carryout[g])
        );

        // Slice model: A1/B1 -> M -> P, OPMODE registered, sync reset.
        logic [17:0] a_r, b_r;
        logic [35:0] m_r;
        logic [7:0]  opm_r;
        logic [47:0] p_r, zmux, xmux;
        logic        co_r;
        logic [48:0] sum;

        always_comb begin
            zmux = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
            xmux = (opm_r[1:0] == 2'b01) ? {12'd0, m_r} : 48'd0;
            sum  = {1'b0, zmux} + {1'b0, xmux};
        end

        always @(posedge clk) begin
            if (dsp_rst[g]) begin
                a_r <= '0; b_r <= '0; m_r <= '0;
                opm_r <= '0; p_r <= '0; co_r <= 1'b0;
            end else begin
                if (dsp_cea[g]) a_r <= dsp_a[g];
                if (dsp_ceb[g]) b_r <= dsp_b[g];
                if (dsp_cem[g]) m_r <= a_r * b_r;
                if (dsp_ceopmode[g]) opm_r <= dsp_opmode[g];
                if (dsp_cep[g]) begin
                    {co_r, p_r} <= sum;
                    if (g == 0) opm_log.push_back(opm_r);
                end
            end
        end

        assign dsp_p[g]        = p_r;
        assign dsp_carryout[g] = co_r;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        int          inst;
        logic [47:0] res;
        logic        carry;
    } exp_t;

    exp_t exp_q [$];

    task automatic push(input int k, input logic [47:0] r, input logic c);
        exp_t e;
        e.inst = k; e.res = r; e.carry = c;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (m_valid[k] && m_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_m_valid", 64'(k + 1), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_inst", 64'(k), 64'(e.inst));
                        check("m_result", m_result[k], e.res);
                        check("m_carry", m_carry[k], e.carry);
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [17:0] a,
                        input logic [17:0] b);
        int t = 0;
        s_valid[k] = 1'b1; s_a[k] = a; s_b[k] = b;
        @(negedge clk);
        while (!s_ready[k] && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready[k]) check("s_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        s_valid[k] = 1'b0; s_a[k] = '0; s_b[k] = '0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            t++;
            @(posedge clk); #1;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_result", m_result[0], 64'd0);
        check("rst_dsp_rst", 64'(dsp_rst), 64'd3);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("dsp_rst_held", 64'(dsp_rst), 64'd3);
        check("s_ready_after_rst", 64'(s_ready), 64'd3);
        @(posedge clk); #1;
        check("dsp_rst_released", 64'(dsp_rst), 64'd0);
    endtask

    task automatic check_opm(input string name, input int terms);
        check({name, "_p_updates"}, 64'(opm_log.size()), 64'(terms));
        for (int i = 0; i < opm_log.size() && i < terms; i++) begin
            check({name, "_opmode"}, 64'(opm_log[i]),
                  (i % 4 == 0) ? 64'h01 : 64'h09);
        end
    endtask

    typedef struct {
        logic [17:0] a [4];
        logic [17:0] b [4];
        logic [47:0] res;
    } grp_t;

    grp_t tbl [6];

    task automatic set_grp(input int i,
                           input logic [17:0] a0, input logic [17:0] b0,
                           input logic [17:0] a1, input logic [17:0] b1,
                           input logic [17:0] a2, input logic [17:0] b2,
                           input logic [17:0] a3, input logic [17:0] b3,
                           input logic [47:0] res);
        tbl[i].a[0] = a0; tbl[i].b[0] = b0;
        tbl[i].a[1] = a1; tbl[i].b[1] = b1;
        tbl[i].a[2] = a2; tbl[i].b[2] = b2;
        tbl[i].a[3] = a3; tbl[i].b[3] = b3;
        tbl[i].res = res;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        set_grp(0, 1, 2, 3, 4, 5, 6, 7, 8, 48'd100);
        set_grp(1, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF,
                   18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF,
                   48'h3FFFE00004);
        set_grp(2, 1000, 1000, 0, 123, 7, 0, 18'h3FFFF, 1, 48'd1262143);
        set_grp(3, 1, 1, 1, 1, 1, 1, 1, 1, 48'd4);
        set_grp(4, 0, 0, 0, 0, 0, 0, 2, 3, 48'd6);
        set_grp(5, 18'h20000, 2, 10, 10, 1, 0, 0, 1, 48'd262244);

        rst = 1'b0; s_valid = '0; s_a = '0; s_b = '0; m_ready = 2'b11;
        #1;
        do_reset(3);
        check("dsp_d_zero", 64'(dsp_d), 64'd0);
        check("dsp_c_zero", 64'(|dsp_c), 64'd0);

        // back-to-back group, latency and one-cycle m_valid
        opm_log.delete();
        push(0, 48'd100, 1'b0);
        send(0, 1, 2); send(0, 3, 4); send(0, 5, 6); send(0, 7, 8);
        idle(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid[0] && n < 20);
        check("latency", 64'(n), 64'(LAT + 1));
        @(negedge clk);
        check("m_valid_one_cycle", 64'(m_valid[0]), 64'd0);
        @(posedge clk); #1;
        check_opm("seq", 4);

        // bubbles between terms
        opm_log.delete();
        push(0, 48'd100, 1'b0);
        for (int i = 1; i <= 7; i += 2) begin
            send(0, 18'(i), 18'(i + 1));
            idle(0);
            @(posedge clk); #1;
        end
        wait_drain();
        check_opm("bubble", 4);

        // table groups streamed back to back
        opm_log.delete();
        for (int g = 0; g < 6; g++) begin
            push(0, tbl[g].res, 1'b0);
            for (int t = 0; t < 4; t++) send(0, tbl[g].a[t], tbl[g].b[t]);
        end
        idle(0);
        wait_drain();
        check_opm("tbl", 24);

        // back-pressure across two groups
        m_ready[0] = 1'b0;
        push(0, 48'd100, 1'b0);
        push(0, 48'd4, 1'b0);
        fork
            begin
                send(0, 1, 2); send(0, 3, 4); send(0, 5, 6); send(0, 7, 8);
                for (int t = 0; t < 4; t++) send(0, 1, 1);
                idle(0);
            end
            begin
                int w = 0;
                @(negedge clk);
                while (!m_valid[0] && w < 50) begin
                    w++;
                    @(negedge clk);
                end
                check("stall_m_valid", 64'(m_valid[0]), 64'd1);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("stall_hold", m_result[0], 64'd100);
                    check("stall_s_ready", 64'(s_ready[0]), 64'd0);
                    check("stall_ce",
                          64'({dsp_cea[0], dsp_ceb[0], dsp_cem[0],
                               dsp_cep[0], dsp_ceopmode[0],
                               dsp_cecarryin[0]}), 64'd0);
                end
                @(posedge clk); #1;
                m_ready[0] = 1'b1;
            end
        join
        wait_drain();

        // reset in the middle of a group
        send(0, 9, 9); send(0, 9, 9);
        idle(0);
        do_reset(2);
        push(0, 48'd16, 1'b0);
        for (int t = 0; t < 4; t++) send(0, 2, 2);
        idle(0);
        wait_drain();

        // single-term groups
        push(1, 48'hFFFF80001, 1'b0);
        send(1, 18'h3FFFF, 18'h3FFFF);
        push(1, 48'd0, 1'b0);
        send(1, 0, 5);
        idle(1);
        wait_drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
